// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the round-robin arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
endpackage

// File: rtl/dec2_to_onehot.sv
// rtl/dec2_to_onehot.sv - gated 2-to-4 one-hot decoder
module dec2_to_onehot
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-requester round-robin arbiter with release and hold limit
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t           r_state;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [7:0]       r_cnt;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_to_nxt;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_pick;
  logic                 w_at_lim;
  logic                 w_release;

  // Rotate so the pointer position sits at bit 0, pick the lowest set bit,
  // then add the pointer back to recover the absolute index.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[r_ptr +: NUM_REQ];

  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign w_pick    = r_ptr + w_off;
  assign w_at_lim  = (r_cnt == HOLD_LIM);
  assign w_release = done | ~req[r_gnt_idx] | w_at_lim;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_gnt_idx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_idx_nxt   = w_pick;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_gnt_idx + 2'd1;
          w_cnt_nxt   = 8'd0;
          // A voluntary release in the same cycle as the limit is not a timeout.
          w_to_nxt    = w_at_lim & ~done & req[r_gnt_idx];
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  assign gnt_valid = (r_state == GRANT);
  assign gnt_idx   = r_gnt_idx;
  assign timeout   = r_timeout;

  dec2_to_onehot u_dec (
    .i_idx    (r_gnt_idx),
    .i_en     (gnt_valid),
    .o_onehot (gnt)
  );
endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one resource slot among requesters 0–3 and drives a one-hot grant vector.
- The grant index is kept as a 2-bit code and expanded to one-hot by a 2→4 decoder instance.
- It sits in front of any single-port resource (bus slot, shared register, output mux).
- It provides fair rotation, explicit release, and a hold-time limit so no requester can monopolise the resource.

## Interface

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced release. Legal range 1–255.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  request vector, bit i = requester i. Level-sensitive.
- done  in  1  current owner releases the resource. Ignored when no grant is active.
- gnt  out  4  one-hot grant, all-zero when idle.
- gnt_idx  out  2  index of the current owner. Holds the last owner when idle.
- gnt_valid  out  1  high while any grant is active; equals |gnt.
- timeout  out  1  one-cycle pulse when a grant was forcibly released by MAX_HOLD.

## Operation

Reset (rst high at an edge, from any state, mid-grant included):
- gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
- Priority pointer ptr=0, hold counter cnt=0, state IDLE.

State IDLE:
- If req≠0: select the first set bit searching ptr, ptr+1, … mod 4.
- Register it into gnt_idx, assert gnt/gnt_valid, set cnt=1, go to GRANT.
- If req=0: stay in IDLE with gnt=0.

State GRANT (owner o = gnt_idx):
- Release occurs if any of the following holds: done=1, req[o]=0, or cnt==MAX_HOLD.
- On release:
  - gnt=0, gnt_valid=0.
  - ptr = o+1 mod 4 (3 wraps to 0).
  - cnt=0, state IDLE.
- Otherwise cnt increments and the grant is held.
- timeout=1 in the cycle after a release only when cnt==MAX_HOLD and done=0 and req[o]=1.
  - Normal release wins ties: done with cnt==MAX_HOLD gives timeout=0.
- Changes to req on non-owner bits during GRANT have no effect.

Fairness:
- After owner o releases, o has lowest priority at the next arbitration.
- With all four requesting continuously, grant order is 0,1,2,3,0,…

Width rules:
- cnt is 8 bits and never exceeds MAX_HOLD.
- ptr and gnt_idx are 2-bit and wrap naturally.

## Timing

- Request-to-grant latency: req sampled at edge k in IDLE → gnt valid after edge k (visible in cycle k+1).
- Release latency: a release condition present at edge k → gnt=0 after edge k.
- Mandatory idle cycle between grants. Earliest re-grant is at edge k+1, giving a one-cycle gap with gnt=0.
- Maximum grant width: MAX_HOLD cycles.
- timeout is high for exactly the one IDLE cycle following a forced release.
- All outputs are registered; no combinational path from req or done to gnt.

## Structure

- Shared package arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam NUM_REQ=4
  - localparam IDX_W=2
- Sub-module dec2_to_onehot:
  - Combinational decode of the registered gnt_idx into 4-bit one-hot, gated by gnt_valid.
  - Instantiated once.
- Priority search (rotate by ptr, find first set, rotate back) stays inside rr_arb4 as combinational logic.

## Test plan

- Reset then req=4'b0000 for 5 cycles → gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- req=4'b1111 held; each owner pulses done in its second grant cycle → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- MAX_HOLD=3, req=4'b0100 held, done=0:
  - gnt=0100 for exactly 3 cycles, then 0000 with timeout=1 for one cycle.
  - Re-grant 0100 on the next cycle.
- ptr=3 (after owner 2 released), req=4'b0011 → grant 0001 (wrap-around), not 0010.
- Owner 1 drops req[1] while done=0 and cnt<MAX_HOLD → gnt=0000 next cycle, timeout=0, ptr=2.
- rst asserted mid-grant with gnt=1000 → next cycle all outputs zero.
  - After rst deasserts with req=4'b1001, the grant goes to 0001 (ptr back at 0).
